// File: rtl/rgb_pkg.sv
// Shared types and constants for the RGB mask memory host.
// Widths, mask op codes and host FSM states.
package rgb_pkg;

  localparam int RGB_W  = 24;
  localparam int ADDR_W = 4;

  localparam logic [2:0] OP_0 = 3'b000;
  localparam logic [2:0] OP_1 = 3'b001;
  localparam logic [2:0] OP_2 = 3'b010;
  localparam logic [2:0] OP_3 = 3'b011;
  localparam logic [2:0] OP_4 = 3'b100;
  localparam logic [2:0] OP_5 = 3'b101;
  localparam logic [2:0] OP_6 = 3'b110;
  localparam logic [2:0] OP_7 = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    WR,
    RD,
    RSP
  } state_t;

endpackage

// File: rtl/rgb_mask_host_if.sv
// Bundle of command, response and memory-side signals.
// slave: host view (cmd in, rsp/mem out); master: environment view.
interface rgb_mask_host_if;
  import rgb_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic              cmd_verify;
  logic [ADDR_W-1:0] cmd_addr;
  logic [RGB_W-1:0]  cmd_rgb;
  logic [2:0]        cmd_op;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [ADDR_W-1:0] rsp_addr;
  logic [RGB_W-1:0]  rsp_rgb;

  logic              mem_mode;
  logic [ADDR_W-1:0] mem_addr;
  logic [RGB_W-1:0]  mem_rgb;
  logic [2:0]        mem_op;
  logic [RGB_W-1:0]  mem_rgb_rd;

  modport slave (
    input  cmd_valid, cmd_write, cmd_verify,
    input  cmd_addr, cmd_rgb, cmd_op,
    input  rsp_ready, mem_rgb_rd,
    output cmd_ready,
    output rsp_valid, rsp_addr, rsp_rgb,
    output mem_mode, mem_addr, mem_rgb, mem_op
  );

  modport master (
    output cmd_valid, cmd_write, cmd_verify,
    output cmd_addr, cmd_rgb, cmd_op,
    output rsp_ready, mem_rgb_rd,
    input  cmd_ready,
    input  rsp_valid, rsp_addr, rsp_rgb,
    input  mem_mode, mem_addr, mem_rgb, mem_op
  );

endinterface

// File: rtl/rgb_rsp_slot.sv
// Single-entry valid/ready holding register for read responses.
// Ports: clk, rst_n, i_load/i_addr/i_rgb in, i_ready in, o_valid/o_addr/o_rgb out.
module rgb_rsp_slot
  import rgb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [RGB_W-1:0]  i_rgb,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [ADDR_W-1:0] o_addr,
  output logic [RGB_W-1:0]  o_rgb
);

  logic              r_valid;
  logic [ADDR_W-1:0] r_addr;
  logic [RGB_W-1:0]  r_rgb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_rgb   <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_addr  <= i_addr;
      r_rgb   <= i_rgb;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_addr  = r_addr;
  assign o_rgb   = r_rgb;

endmodule

// File: rtl/rgb_mask_host.sv
// Sequencer driving the 16-entry RGB mask memory from a cmd/rsp port.
// Ports: CLK, RSTn (async, active low), bus (slave: cmd, rsp, mem sides).
module rgb_mask_host
  import rgb_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input logic            CLK,
  input logic            RSTn,
  rgb_mask_host_if.slave bus
);

  localparam logic [2:0] LAT_LAST = 3'(RD_LAT - 1);

  state_t            r_state;
  logic              r_verify;
  logic              r_mode;
  logic [2:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [RGB_W-1:0]  r_rgb;
  logic [2:0]        r_op;
  logic              w_cap;

  // Capture on the last RD cycle; RGBout has settled by then.
  assign w_cap = (r_state == RD) && (r_cnt == LAT_LAST);

  assign bus.cmd_ready = (r_state == IDLE);
  assign bus.mem_mode  = r_mode;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_rgb   = r_rgb;
  assign bus.mem_op    = r_op;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state  <= IDLE;
      r_verify <= 1'b0;
      r_mode   <= 1'b0;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_rgb    <= '0;
      r_op     <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.cmd_valid) begin
            r_verify <= bus.cmd_verify;
            r_addr   <= bus.cmd_addr;
            r_cnt    <= '0;
            if (bus.cmd_write) begin
              // rgb/op only move on writes so RGBin/Op stay quiet.
              r_rgb   <= bus.cmd_rgb;
              r_op    <= bus.cmd_op;
              r_mode  <= 1'b1;
              r_state <= WR;
            end else begin
              r_state <= RD;
            end
          end
        end
        WR: begin
          r_mode  <= 1'b0;
          r_cnt   <= '0;
          r_state <= r_verify ? RD : IDLE;
        end
        RD: begin
          if (w_cap) r_state <= RSP;
          else       r_cnt   <= r_cnt + 3'd1;
        end
        RSP: begin
          if (bus.rsp_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  rgb_rsp_slot u_slot (
    .clk     (CLK),
    .rst_n   (RSTn),
    .i_load  (w_cap),
    .i_addr  (r_addr),
    .i_rgb   (bus.mem_rgb_rd),
    .i_ready (bus.rsp_ready),
    .o_valid (bus.rsp_valid),
    .o_addr  (bus.rsp_addr),
    .o_rgb   (bus.rsp_rgb)
  );

endmodule

// File: tb/tb_rgb_mask_host.sv
// Bench for rgb_mask_host with a behavioural mask memory (RD_LAT=1).
// Transaction-level model checked every cycle plus literal pins.
module tb_rgb_mask_host;
  import rgb_pkg::*;

  localparam int LAT = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rgb_mask_host_if bus();

  rgb_mask_host #(.RD_LAT(LAT)) dut (
    .CLK  (clk),
    .RSTn (rst_n),
    .bus  (bus.slave)
  );

  // Mask op semantics of the memory: op 5 brightens every channel
  // by one, red saturating at 8'h79; op 7 inverts; others store.
  function automatic logic [23:0] op_fn(input logic [2:0] op,
                                        input logic [23:0] d);
    logic [7:0] r, g, b;
    {r, g, b} = d;
    op_fn = d;
    case (op)
      OP_0, OP_1, OP_2, OP_3, OP_4, OP_6: op_fn = d;
      OP_5: op_fn = {(r < 8'h79) ? r + 8'd1 : r, g + 8'd1, b + 8'd1};
      OP_7: op_fn = ~d;
      default: op_fn = d;
    endcase
  endfunction

  // Memory fixture: synchronous write, asynchronous read.
  logic [23:0] fmem [16];
  initial for (int i = 0; i < 16; i++) fmem[i] = '0;
  always @(posedge clk)
    if (bus.mem_mode) fmem[bus.mem_addr] <= op_fn(bus.mem_op, bus.mem_rgb);
  assign bus.mem_rgb_rd = fmem[bus.mem_addr];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction model: per-cycle expectations from latency rules.
  logic [23:0] mmem [16];
  initial for (int i = 0; i < 16; i++) mmem[i] = '0;
  int          cyc = 0;
  int          wr_due = -1;
  int          rsp_due = 0;
  int          free_at = 0;
  bit          rsp_pend = 0;
  logic [3:0]  e_waddr, e_raddr;
  logic [23:0] e_wrgb, e_rrgb;
  logic [2:0]  e_wop;
  logic [23:0] last_rgb = '0;
  logic [2:0]  last_op = '0;
  int          n_wr = 0;
  int          n_hs = 0;
  logic [3:0]  got_addr = '0;
  logic [23:0] got_rgb = '0;

  always @(negedge clk) begin
    bit ew, ev, rdy;
    if (!rst_n) begin
      chk("rst_mode", bus.mem_mode, 0);
      chk("rst_maddr", bus.mem_addr, 0);
      chk("rst_mrgb", bus.mem_rgb, 0);
      chk("rst_mop", bus.mem_op, 0);
      chk("rst_rvalid", bus.rsp_valid, 0);
      chk("rst_raddr", bus.rsp_addr, 0);
      chk("rst_rrgb", bus.rsp_rgb, 0);
      chk("rst_ready", bus.cmd_ready, 1);
      wr_due = -1; rsp_pend = 0; free_at = 0;
      last_rgb = '0; last_op = '0;
    end else begin
      ew = (wr_due == cyc);
      chk("mem_mode", bus.mem_mode, ew);
      if (bus.mem_mode) n_wr++;
      if (ew) begin
        chk("wr_addr", bus.mem_addr, e_waddr);
        chk("wr_rgb", bus.mem_rgb, e_wrgb);
        chk("wr_op", bus.mem_op, e_wop);
        last_rgb = e_wrgb; last_op = e_wop;
      end else begin
        chk("hold_rgb", bus.mem_rgb, last_rgb);
        chk("hold_op", bus.mem_op, last_op);
      end
      ev = rsp_pend && (cyc >= rsp_due);
      chk("rsp_valid", bus.rsp_valid, ev);
      if (ev) begin
        chk("rsp_addr", bus.rsp_addr, e_raddr);
        chk("rsp_rgb", bus.rsp_rgb, e_rrgb);
      end
      rdy = !rsp_pend && (cyc >= free_at);
      chk("cmd_ready", bus.cmd_ready, rdy);
      if (ev && bus.rsp_ready) begin
        n_hs++;
        got_addr = bus.rsp_addr; got_rgb = bus.rsp_rgb;
        rsp_pend = 0; free_at = cyc + 1;
      end
      if (rdy && bus.cmd_valid) begin
        if (bus.cmd_write) begin
          wr_due = cyc + 1;
          e_waddr = bus.cmd_addr; e_wrgb = bus.cmd_rgb; e_wop = bus.cmd_op;
          mmem[bus.cmd_addr] = op_fn(bus.cmd_op, bus.cmd_rgb);
          free_at = cyc + 2;
          if (bus.cmd_verify) begin
            rsp_pend = 1; rsp_due = cyc + 2 + LAT;
            e_raddr = bus.cmd_addr; e_rrgb = mmem[bus.cmd_addr];
          end
        end else begin
          rsp_pend = 1; rsp_due = cyc + 1 + LAT;
          e_raddr = bus.cmd_addr; e_rrgb = mmem[bus.cmd_addr];
        end
      end
    end
    cyc++;
  end

  task automatic send(input bit w, input bit v, input logic [3:0] a,
                      input logic [23:0] d, input logic [2:0] op);
    bit ok = 0;
    bus.cmd_valid = 1'b1; bus.cmd_write = w; bus.cmd_verify = v;
    bus.cmd_addr = a; bus.cmd_rgb = d; bus.cmd_op = op;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = bus.cmd_ready;
      @(posedge clk); #2;
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: got no accept want accept");
    end
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'($urandom); bus.cmd_verify = 1'($urandom);
    bus.cmd_addr = 4'($urandom); bus.cmd_rgb = 24'($urandom);
    bus.cmd_op = 3'($urandom);
  endtask

  task automatic drain();
    bit ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = bus.cmd_ready && !bus.rsp_valid;
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: got busy want idle");
    end
    @(posedge clk); #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    int w0, h0;
    bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_verify = 0;
    bus.cmd_addr = '0; bus.cmd_rgb = '0; bus.cmd_op = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #2;

    // plain write
    w0 = n_wr; h0 = n_hs;
    send(1, 0, 4'hA, 24'h81C342, 3'b000);
    @(negedge clk);
    chk("t2_mode1", bus.mem_mode, 1);
    chk("t2_addr", bus.mem_addr, 4'hA);
    chk("t2_rgb", bus.mem_rgb, 24'h81C342);
    chk("t2_busy", bus.cmd_ready, 0);
    @(negedge clk);
    chk("t2_mode0", bus.mem_mode, 0);
    chk("t2_ready", bus.cmd_ready, 1);
    @(posedge clk); #2;
    drain();
    chk("t2_nwr", n_wr - w0, 1);
    chk("t2_nrsp", n_hs - h0, 0);

    // writes then reads
    send(1, 0, 4'h0, 24'h727662, 3'b011); drain();
    send(1, 0, 4'h5, 24'h796379, 3'b101); drain();
    send(0, 0, 4'h5, 24'h0, 3'b0); drain();
    chk("t3_addr5", got_addr, 4'h5);
    chk("t3_rgb5", got_rgb, 24'h79647A);
    send(0, 0, 4'h0, 24'h0, 3'b0); drain();
    chk("t3_addr0", got_addr, 4'h0);
    chk("t3_rgb0", got_rgb, 24'h727662);
    chk("pin_m5", mmem[5], 24'h79647A);

    // verified write
    send(1, 1, 4'hE, 24'h636567, 3'b101);
    @(negedge clk); chk("t4_c1", bus.rsp_valid, 0);
    @(negedge clk); chk("t4_c2", bus.rsp_valid, 0);
    @(negedge clk);
    chk("t4_c3", bus.rsp_valid, 1);
    chk("t4_rgb", bus.rsp_rgb, 24'h646668);
    chk("t4_addr", bus.rsp_addr, 4'hE);
    @(posedge clk); #2;
    drain();
    chk("pin_mE", mmem[14], 24'h646668);

    // backpressure
    bus.rsp_ready = 1'b0;
    send(0, 0, 4'hA, 24'h0, 3'b0);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t5_valid", bus.rsp_valid, 1);
      chk("t5_rgb", bus.rsp_rgb, 24'h81C342);
      chk("t5_addr", bus.rsp_addr, 4'hA);
      chk("t5_ready", bus.cmd_ready, 0);
      chk("t5_mode", bus.mem_mode, 0);
    end
    @(posedge clk); #2;
    bus.rsp_ready = 1'b1;
    drain();

    // stream, cmd_valid held high across commands
    w0 = n_wr; h0 = n_hs;
    send(1, 0, 4'h1, 24'h112233, 3'b000);
    send(0, 0, 4'h1, 24'h0, 3'b0);
    send(1, 0, 4'h2, 24'h0A0B0C, 3'b101);
    send(0, 0, 4'h2, 24'h0, 3'b0);
    send(1, 0, 4'h3, 24'h445566, 3'b111);
    send(0, 0, 4'h3, 24'h0, 3'b0);
    send(1, 0, 4'h1, 24'h010203, 3'b011);
    send(0, 0, 4'h1, 24'h0, 3'b0);
    drain();
    chk("t6_nwr", n_wr - w0, 4);
    chk("t6_nrsp", n_hs - h0, 4);
    chk("t6_last", got_rgb, 24'h010203);
    chk("pin_m2", mmem[2], 24'h0B0C0D);
    chk("pin_m3", mmem[3], 24'hBBAA99);

    // reset in the middle of a read
    h0 = n_hs;
    send(0, 0, 4'h5, 24'h0, 3'b0);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (4) @(posedge clk); #2;
    chk("t1_norsp", n_hs - h0, 0);
    send(0, 0, 4'h5, 24'h0, 3'b0); drain();
    chk("t1_after", got_rgb, 24'h79647A);
    chk("t1_nrsp", n_hs - h0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
